// File: rtl/egg_timer_ctrl.sv
// Egg timer user controller: setpoint editing, countdown start
// handshake, live/setpoint display and a timed silenceable alarm.
module egg_timer_ctrl #(
  parameter int STEP_SEC     = 30,
  parameter int MAX_SEC      = 3600,
  parameter int DEFAULT_SEC  = 180,
  parameter int ALARM_CYCLES = 10000,
  parameter int BEEP_HALF    = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_go,
  input  logic        timer_done,
  input  logic [11:0] timer_count,
  output logic [11:0] load_value,
  output logic        start,
  output logic        busy,
  output logic        alarm,
  output logic        beep,
  output logic [11:0] display_sec
);

  localparam int AW = $clog2(ALARM_CYCLES + 1);
  localparam int BW = $clog2(BEEP_HALF + 1);
  localparam logic [12:0] STEP13 = 13'(STEP_SEC);
  localparam logic [12:0] MAX13  = 13'(MAX_SEC);
  localparam logic [AW-1:0] ALM_LAST = AW'(ALARM_CYCLES - 1);
  localparam logic [BW-1:0] BH_LAST  = BW'(BEEP_HALF - 1);

  typedef enum logic [1:0] {
    S_SET, S_ARM, S_RUN, S_ALARM
  } state_t;

  state_t        r_state, w_next;
  logic [11:0]   r_sp, w_sp_next;
  logic [12:0]   w_sum, w_dif;
  logic [11:0]   w_up, w_dn;
  logic          w_any_btn;
  logic [AW-1:0] r_acnt;
  logic [BW-1:0] r_bcnt;
  logic          r_start, r_busy, r_alarm, r_beep;

  assign w_sum     = {1'b0, r_sp} + STEP13;
  assign w_dif     = {1'b0, r_sp} - STEP13;
  assign w_up      = (w_sum > MAX13) ? MAX13[11:0] : w_sum[11:0];
  assign w_dn      = ({1'b0, r_sp} < STEP13) ? 12'd0 : w_dif[11:0];
  assign w_any_btn = btn_up | btn_down | btn_go;

  always_comb begin
    w_next    = r_state;
    w_sp_next = r_sp;
    unique case (r_state)
      S_SET: begin
        // go outranks up/down; zero setpoint cannot start
        if (btn_go) begin
          if (r_sp != 12'd0) w_next = S_ARM;
        end else if (btn_up && !btn_down) begin
          w_sp_next = w_up;
        end else if (btn_down && !btn_up) begin
          w_sp_next = w_dn;
        end
      end
      S_ARM: w_next = S_RUN;
      S_RUN: if (timer_done) w_next = S_ALARM;
      S_ALARM: begin
        if (w_any_btn) w_next = S_SET;
        else if (r_acnt == ALM_LAST) w_next = S_SET;
      end
      default: w_next = S_SET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_SET;
      r_sp    <= 12'(DEFAULT_SEC);
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sp    <= w_sp_next;
      r_start <= (w_next == S_ARM);
      r_busy  <= (w_next == S_ARM) || (w_next == S_RUN);
      r_alarm <= (w_next == S_ALARM);
    end
  end

  // alarm duration and beep phase, both restart on ALARM entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acnt <= '0;
      r_bcnt <= '0;
      r_beep <= 1'b0;
    end else if (r_state != S_ALARM) begin
      r_acnt <= '0;
      r_bcnt <= '0;
      r_beep <= (w_next == S_ALARM);
    end else if (w_next == S_ALARM) begin
      r_acnt <= r_acnt + AW'(1);
      if (r_bcnt == BH_LAST) begin
        r_bcnt <= '0;
        r_beep <= ~r_beep;
      end else begin
        r_bcnt <= r_bcnt + BW'(1);
      end
    end else begin
      r_acnt <= '0;
      r_bcnt <= '0;
      r_beep <= 1'b0;
    end
  end

  assign start       = r_start;
  assign busy        = r_busy;
  assign alarm       = r_alarm;
  assign beep        = r_beep;
  assign load_value  = r_sp;
  assign display_sec = (r_state == S_RUN) ? timer_count : r_sp;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Self-checking bench for egg_timer_ctrl with small parameters
// so the alarm window and beep pattern are quick to walk through.
module tb_egg_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_go = 1'b0;
  logic        timer_done = 1'b0;
  logic [11:0] timer_count = 12'd0;
  logic [11:0] load_value;
  logic        start, busy, alarm, beep;
  logic [11:0] display_sec;

  int checks = 0;
  int errors = 0;
  int m_sp   = 60;
  int exp_q[$];

  egg_timer_ctrl #(
    .STEP_SEC(30), .MAX_SEC(120), .DEFAULT_SEC(60),
    .ALARM_CYCLES(20), .BEEP_HALF(2)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_go(btn_go),
    .timer_done(timer_done), .timer_count(timer_count),
    .load_value(load_value), .start(start), .busy(busy),
    .alarm(alarm), .beep(beep), .display_sec(display_sec)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int e;
    rst = 1'b1;
    tick();
    e = 60;
    checks++;
    if ({start, busy, alarm, beep} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {start, busy, alarm, beep});
    end
    checks++;
    if (load_value !== 12'(e) || display_sec !== 12'(e)) begin
      errors++;
      $display("FAIL reset_sp: got %0d/%0d expected %0d",
               load_value, display_sec, e);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_setpoint;
    int e;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin
        btn_up = 1'b1;
        m_sp = (m_sp + 30 > 120) ? 120 : m_sp + 30;
      end else begin
        btn_down = 1'b1;
        m_sp = (m_sp < 30) ? 0 : m_sp - 30;
      end
      exp_q.push_back(m_sp);
      tick();
      btn_up = 1'b0;
      btn_down = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (load_value !== 12'(e) || display_sec !== 12'(e)) begin
        errors++;
        $display("FAIL setpoint_%0d: got %0d/%0d expected %0d",
                 i, load_value, display_sec, e);
      end
    end
  endtask

  task automatic test_go_zero;
    btn_go = 1'b1;
    tick();
    btn_go = 1'b0;
    timer_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({start, busy, alarm} !== 3'b000 || display_sec !== 12'd0) begin
        errors++;
        $display("FAIL go_zero_%0d: got s/b/a=%b disp=%0d expected 000/0",
                 i, {start, busy, alarm}, display_sec);
      end
      tick();
    end
    timer_done = 1'b0;
  endtask

  task automatic test_start;
    for (int i = 0; i < 2; i++) begin
      btn_up = 1'b1;
      m_sp = m_sp + 30;
      tick();
      btn_up = 1'b0;
    end
    btn_go = 1'b1;
    tick();
    btn_go = 1'b0;
    checks++;
    if (start !== 1'b1 || busy !== 1'b1 || load_value !== 12'(m_sp)) begin
      errors++;
      $display("FAIL start_n1: got s=%b b=%b ld=%0d expected 1 1 %0d",
               start, busy, load_value, m_sp);
    end
    timer_count = 12'd45;
    tick();
    checks++;
    if (start !== 1'b0 || busy !== 1'b1 || load_value !== 12'(m_sp)) begin
      errors++;
      $display("FAIL start_n2: got s=%b b=%b ld=%0d expected 0 1 %0d",
               start, busy, load_value, m_sp);
    end
    checks++;
    if (display_sec !== 12'd45) begin
      errors++;
      $display("FAIL disp_run: got %0d expected 45", display_sec);
    end
    timer_count = 12'd44;
    #1;
    checks++;
    if (display_sec !== 12'd44) begin
      errors++;
      $display("FAIL disp_follow: got %0d expected 44", display_sec);
    end
    tick();
    checks++;
    if (start !== 1'b0 || load_value !== 12'(m_sp) || alarm !== 1'b0) begin
      errors++;
      $display("FAIL start_n3: got s=%b ld=%0d a=%b expected 0 %0d 0",
               start, load_value, alarm, m_sp);
    end
  endtask

  task automatic test_alarm;
    int e;
    timer_done = 1'b1;
    for (int k = 0; k < 20; k++) exp_q.push_back(((k / 2) % 2 == 0) ? 1 : 0);
    tick();
    timer_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (alarm !== 1'b1 || beep !== e[0]) begin
        errors++;
        $display("FAIL alarm_cyc%0d: got a=%b beep=%b expected 1 %0d",
                 k, alarm, beep, e);
      end
      tick();
    end
    checks++;
    if ({alarm, beep, busy} !== 3'b000 || display_sec !== 12'(m_sp)) begin
      errors++;
      $display("FAIL alarm_end: got a/b/busy=%b disp=%0d expected 000 %0d",
               {alarm, beep, busy}, display_sec, m_sp);
    end
  endtask

  task automatic test_silence;
    btn_go = 1'b1;
    tick();
    btn_go = 1'b0;
    tick();
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    repeat (4) tick();
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL silence_pre: got a=%b expected 1", alarm);
    end
    btn_down = 1'b1;
    tick();
    btn_down = 1'b0;
    checks++;
    if ({alarm, beep} !== 2'b00 || load_value !== 12'(m_sp)) begin
      errors++;
      $display("FAIL silence: got a/b=%b ld=%0d expected 00 %0d",
               {alarm, beep}, load_value, m_sp);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || load_value !== 12'(m_sp)) begin
      errors++;
      $display("FAIL silence_after: got busy=%b ld=%0d expected 0 %0d",
               busy, load_value, m_sp);
    end
  endtask

  task automatic test_back_to_back;
    btn_up = 1'b1;
    m_sp = m_sp + 30;
    tick();
    btn_up = 1'b0;
    btn_go = 1'b1;
    tick();
    btn_go = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || display_sec !== timer_count) begin
      errors++;
      $display("FAIL run_busy: got busy=%b disp=%0d expected 1 %0d",
               busy, display_sec, timer_count);
    end
    #2 rst = 1'b1;
    #1;
    m_sp = 60;
    checks++;
    if ({start, busy, alarm, beep} !== 4'b0000 ||
        display_sec !== 12'(m_sp)) begin
      errors++;
      $display("FAIL rst_run: got flags=%b disp=%0d expected 0000 %0d",
               {start, busy, alarm, beep}, display_sec, m_sp);
    end
    tick();
    rst = 1'b0;
    btn_up = 1'b1;
    btn_down = 1'b1;
    tick();
    btn_up = 1'b0;
    btn_down = 1'b0;
    checks++;
    if (load_value !== 12'(m_sp)) begin
      errors++;
      $display("FAIL up_down: got %0d expected %0d", load_value, m_sp);
    end
    btn_go = 1'b1;
    btn_up = 1'b1;
    tick();
    btn_go = 1'b0;
    btn_up = 1'b0;
    checks++;
    if (start !== 1'b1 || load_value !== 12'(m_sp)) begin
      errors++;
      $display("FAIL go_wins: got s=%b ld=%0d expected 1 %0d",
               start, load_value, m_sp);
    end
  endtask

  initial begin
    test_reset();
    test_setpoint();
    test_go_zero();
    test_start();
    test_alarm();
    test_silence();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
